// File: rtl/if_scratchpad.sv
// -----------------------------------------------------------------------------
// if_scratchpad
//   Input-feature scratchpad. Collects one row of words from the global buffer,
//   holds it while a read address generator fetches words (latency 1), and
//   releases the row when the consumer signals row_done.
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | empty, waiting for the first word of a row
//   S_FILL  | partial row stored, still accepting words
//   S_READY | row complete, reads honoured, writes blocked
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-low reset
//   wr_data    in   row word from global buffer
//   wr_valid   in   wr_data valid
//   wr_last    in   final word of the row
//   wr_ready   out  word accepted this cycle when wr_valid is high
//   rd_en      in   read request
//   rd_addr    in   read pointer
//   rd_data    out  registered read word
//   rd_valid   out  one-cycle pulse per honoured read
//   row_ready  out  complete row resident
//   row_done   in   consumer releases the row
//   count      out  words currently stored
//   addr_err   out  sticky out-of-range read flag
//
// Build option
//   IF_SCRATCHPAD_ADDR_CHECK_EN : reads at rd_addr >= count return 0 and set
//   addr_err. Undefined: addr_err is 0 and reads are unchecked.
// -----------------------------------------------------------------------------
module if_scratchpad #(
  parameter int DATA_WIDTH   = 16,
  parameter int POINTER_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  input  logic                    wr_last,
  output logic                    wr_ready,
  input  logic                    rd_en,
  input  logic [POINTER_SIZE-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    row_ready,
  input  logic                    row_done,
  output logic [POINTER_SIZE:0]   count,
  output logic                    addr_err
);

  localparam int DEPTH = 2 ** POINTER_SIZE;
  localparam logic [POINTER_SIZE:0] L_DEPTH = {1'b1, {POINTER_SIZE{1'b0}}};
  localparam logic [POINTER_SIZE:0] L_ONE   = {{POINTER_SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [POINTER_SIZE:0]   r_count;
  logic [POINTER_SIZE:0]   w_count_inc;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_wr_ready;
  logic                    w_wr_acc;
  logic                    w_rd_hon;
  logic                    w_release;

  // rst is folded in so the upstream sees no ready while reset is held.
  assign w_wr_ready  = (r_state != S_READY) && (r_count < L_DEPTH) && rst;
  assign w_wr_acc    = wr_valid && w_wr_ready;
  assign w_rd_hon    = rd_en && (r_state == S_READY);
  assign w_release   = row_done && (r_state == S_READY);
  assign w_count_inc = r_count + L_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_wr_acc) begin
          // A full memory closes the row even without wr_last.
          if (wr_last || (w_count_inc == L_DEPTH)) begin
            w_state_nxt = S_READY;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end
      S_READY: begin
        if (row_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_release) begin
      r_count <= '0;
    end else if (w_wr_acc) begin
      r_count <= w_count_inc;
    end
  end

  // Storage is deliberately not reset; a row is invalidated by clearing count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_count[POINTER_SIZE-1:0]] <= wr_data;
    end
  end

`ifdef IF_SCRATCHPAD_ADDR_CHECK_EN
  logic w_oob;
  logic r_addr_err;

  assign w_oob     = ({1'b0, rd_addr} >= r_count);
  assign w_rd_word = w_oob ? '0 : r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr_err <= 1'b0;
    end else if (w_rd_hon && w_oob) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_rd_word = r_mem[rd_addr];
  assign addr_err  = 1'b0;
`endif

  // A read coinciding with row_done still sees the old row: memory and count
  // are only cleared/overwritten after this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_hon;
      if (w_rd_hon) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign wr_ready  = w_wr_ready;
  assign row_ready = (r_state == S_READY);
  assign count     = r_count;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_if_scratchpad.sv
module tb_if_scratchpad;

  localparam int DW = 16;
  localparam int PS = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_en;
  logic [PS-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          row_ready;
  logic          row_done;
  logic [PS:0]   count;
  logic          addr_err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb_q [$];

  if_scratchpad #(.DATA_WIDTH(DW), .POINTER_SIZE(PS)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .row_ready(row_ready),
    .row_done (row_done),
    .count    (count),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 rd_data=%0h expected no read", rd_data);
      end else begin
        chk("rd_data", {16'h0, rd_data}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic last);
    wr_data  = d;
    wr_valid = 1'b1;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic rd(input logic [PS-1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    rd_en   = 1'b1;
    sb_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] oob_exp;
    logic          err_exp;
`ifdef IF_SCRATCHPAD_ADDR_CHECK_EN
    oob_exp = 16'h0000;
    err_exp = 1'b1;
`else
    oob_exp = 16'hA507;
    err_exp = 1'b0;
`endif
    rst = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; row_done = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr_err", addr_err, 0);
    rst = 1'b1;
    #1;
    chk("idle_wr_ready", wr_ready, 1);

    // Full-depth fill without wr_last.
    for (int i = 0; i < 255; i++) wr(16'hA500 + 16'(i), 1'b0);
    chk("fill255_count", count, 255);
    chk("fill255_row_ready", row_ready, 0);
    wr(16'hA5FF, 1'b0);
    chk("fill256_count", count, 256);
    chk("fill256_row_ready", row_ready, 1);
    chk("fill256_wr_ready", wr_ready, 0);
    wr(16'hDEAD, 1'b1);
    chk("w257_count", count, 256);
    chk("w257_row_ready", row_ready, 1);
    rd(8'd255, 16'hA5FF);
    rd(8'd7, 16'hA507);
    row_done = 1'b1;
    tick();
    row_done = 1'b0;
    chk("rel_count", count, 0);
    chk("rel_row_ready", row_ready, 0);
    chk("rel_wr_ready", wr_ready, 1);

    // Five-word row.
    wr(16'h11, 1'b0); wr(16'h12, 1'b0); wr(16'h13, 1'b0); wr(16'h14, 1'b0);
    chk("row4_row_ready", row_ready, 0);
    chk("row4_count", count, 4);
    wr(16'h15, 1'b1);
    chk("row5_count", count, 5);
    chk("row5_row_ready", row_ready, 1);
    chk("row5_wr_ready", wr_ready, 0);
    wr(16'h99, 1'b1);
    chk("blocked_count", count, 5);

    // Back-to-back reads.
    rd(8'd0, 16'h11);
    rd(8'd1, 16'h12);
    rd(8'd2, 16'h13);
    tick();
    chk("b2b_q_drained", sb_q.size(), 0);

    // Out-of-range read.
    rd(8'd7, oob_exp);
    chk("oob_addr_err", addr_err, err_exp);
    tick();
    chk("oob_addr_err_sticky", addr_err, err_exp);

    // Release together with a read of the old row.
    row_done = 1'b1; rd_en = 1'b1; rd_addr = 8'd4;
    sb_q.push_back(16'h15);
    tick();
    row_done = 1'b0; rd_en = 1'b0;
    chk("relrd_count", count, 0);
    chk("relrd_row_ready", row_ready, 0);
    chk("relrd_wr_ready", wr_ready, 1);
    chk("relrd_addr_err", addr_err, err_exp);

    // Read outside READY is ignored.
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_data_hold", rd_data, 16'h15);

    // row_done outside READY, then reset mid-FILL.
    wr(16'h21, 1'b0); wr(16'h22, 1'b0); wr(16'h23, 1'b0);
    chk("fill3_count", count, 3);
    row_done = 1'b1;
    tick();
    row_done = 1'b0;
    chk("fill_rowdone_count", count, 3);
    chk("fill_rowdone_row_ready", row_ready, 0);
    rst = 1'b0;
    tick();
    chk("midrst_count", count, 0);
    chk("midrst_row_ready", row_ready, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_addr_err", addr_err, 0);
    rst = 1'b1;
    wr(16'h31, 1'b1);
    chk("newrow_count", count, 1);
    chk("newrow_row_ready", row_ready, 1);
    rd(8'd0, 16'h31);

    // Reset with a read request in READY: no rd_valid.
    rd_en = 1'b1; rd_addr = 8'd0; rst = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("rstrd_rd_valid", rd_valid, 0);
    chk("rstrd_rd_data", rd_data, 0);
    chk("rstrd_row_ready", row_ready, 0);
    rst = 1'b1;
    tick(); tick();
    chk("final_q_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_scratchpad.md
IF_SCRATCHPAD -- requirements
Module: if_scratchpad

Interface
REQ-001 The parameter list SHALL be:
- DATA_WIDTH, default 16, width of one input-feature word.
- POINTER_SIZE, default 8, address width.
- DEPTH = 2^POINTER_SIZE words.
REQ-002 The port list SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_data  in  DATA_WIDTH  row word from global buffer.
- wr_valid  in  1  wr_data valid.
- wr_last  in  1  qualifies the final word of a row.
- wr_ready  out  1  scratchpad accepts a word this cycle.
- rd_en  in  1  read request from read address generator.
- rd_addr  in  POINTER_SIZE  read pointer.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_valid  out  1  rd_data valid.
- row_ready  out  1  complete row resident.
- row_done  in  1  consumer releases current row.
- count  out  POINTER_SIZE+1  words currently stored.
- addr_err  out  1  sticky out-of-range read flag.

Function
REQ-003 The FSM SHALL have states IDLE (empty), FILL (partial row), READY (row complete).
REQ-004 wr_ready SHALL equal (state != READY) && (count < DEPTH) && rst.
REQ-005 A write SHALL occur on a cycle with wr_valid && wr_ready: memory[count] <= wr_data, count <= count+1.
REQ-006 State transitions SHALL be:
- IDLE->FILL on an accepted write without wr_last.
- IDLE/FILL->READY on an accepted write with wr_last, or when an accepted write makes count == DEPTH.
REQ-007 row_ready SHALL be high exactly while state == READY.
REQ-008 rd_en SHALL be honoured only in READY; rd_data/rd_valid SHALL appear one cycle after rd_en (latency 1, one read per cycle, back-to-back allowed).
REQ-009 rd_valid SHALL be a one-cycle pulse per honoured rd_en; rd_en outside READY SHALL produce no rd_valid and SHALL leave rd_data unchanged.
REQ-010 row_done in READY SHALL return to IDLE and clear count to 0 on the next edge; row_done outside READY SHALL be ignored.
REQ-011 When row_done and rd_en are both asserted in READY, the read SHALL be serviced with the old row's data, and the release SHALL take effect in the same edge.
REQ-012 wr_valid while wr_ready is low SHALL be ignored with no state change; the upstream holds the word.
REQ-013 wr_last on a word that is not accepted SHALL have no effect.
REQ-014 count SHALL never exceed DEPTH.

Reset
REQ-015 While rst == 0 at a rising edge, the block SHALL reset: state = IDLE, count = 0, rd_data = 0, rd_valid = 0, addr_err = 0, row_ready = 0, wr_ready = 0.
REQ-016 Memory contents SHALL NOT be reset.
REQ-017 A reset asserted mid-FILL or mid-READY SHALL discard the row; any read in flight SHALL produce no rd_valid.

Configuration
REQ-018 Macro IF_SCRATCHPAD_ADDR_CHECK_EN SHALL control out-of-range read handling.
- Defined: an honoured read with rd_addr >= count returns rd_data = 0 and sets addr_err, which stays set until reset.
- Undefined: addr_err SHALL be tied 0, and reads SHALL return memory[rd_addr] unconditionally.

Verification
REQ-019 Write 5 words 0x11..0x15 with wr_last on 0x15 -> count = 5, row_ready rises the cycle after the 5th accept, and wr_ready drops.
REQ-020 In READY, rd_en with rd_addr = 0,1,2 on consecutive cycles -> rd_data = 0x11, 0x12, 0x13 one cycle after each request, with rd_valid high for 3 cycles.
REQ-021 Fill 256 words without wr_last -> READY entered with count = 256; a 257th wr_valid is not accepted.
REQ-022 With the macro defined, count = 5 and rd_addr = 7 -> rd_data = 0 and addr_err = 1 persists. Without the macro -> addr_err = 0.
REQ-023 row_done and rd_en (addr 4) in the same cycle -> next cycle rd_data = 0x15 and rd_valid = 1, state IDLE, count = 0, wr_ready = 1.
REQ-024 rst = 0 during FILL with count = 3 -> next cycle count = 0, state IDLE, row_ready = 0; a new row then loads from address 0.
